// File: rtl/cotm32_csr_file.sv
// cotm32_csr_file: machine-mode CSR file and trap/mret sequencer; optional mcycle/minstret under `COTM32_CSR_COUNTERS_EN
module cotm32_csr_file #(
    parameter int               MXLEN       = 32,
    parameter logic [MXLEN-1:0] HART_ID     = '0,
    parameter logic [MXLEN-1:0] RESET_MTVEC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             csr_en,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_wdata,
    input  logic             csr_wr_suppress,
    output logic [MXLEN-1:0] csr_rdata,
    output logic             csr_illegal,
    input  logic             trap_req,
    input  logic [MXLEN-1:0] trap_cause,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic [MXLEN-1:0] trap_val,
    input  logic             mret_req,
    input  logic             inst_retire,
    output logic             redirect_valid,
    output logic [MXLEN-1:0] redirect_pc,
    output logic             mstatus_mie
);
    function automatic logic [MXLEN-1:0] legal_tvec(input logic [MXLEN-1:0] v);
        return v[1] ? {v[MXLEN-1:2], 2'b00} : v;
    endfunction

    logic             mie, mpie;
    logic [MXLEN-1:0] mtvec, mepc, mcause, mtval, mscratch;
    logic [MXLEN-1:0] mstatus_val, old_val, new_val, tvec_base, trap_target;
    logic             hit, wr_req, wr_en, unused_bits;
`ifdef COTM32_CSR_COUNTERS_EN
    logic [63:0]      mcycle, minstret;
    assign unused_bits = trap_cause[MXLEN-2];
`else
    assign unused_bits = trap_cause[MXLEN-2] ^ inst_retire;
`endif

    assign mstatus_mie = mie;
    assign mstatus_val = MXLEN'({2'b11, 3'b000, mpie, 3'b000, mie, 3'b000});

    // address decode: select the current value of the addressed CSR
    always_comb begin
        hit     = 1'b1;
        old_val = '0;
        case (csr_addr)
            12'h300: old_val = mstatus_val;
            12'h305: old_val = mtvec;
            12'h340: old_val = mscratch;
            12'h341: old_val = mepc;
            12'h342: old_val = mcause;
            12'h343: old_val = mtval;
            12'hF14: old_val = HART_ID;
`ifdef COTM32_CSR_COUNTERS_EN
            12'hB00, 12'hC00: old_val = MXLEN'(mcycle[31:0]);
            12'hB80, 12'hC80: old_val = MXLEN'(mcycle[63:32]);
            12'hB02, 12'hC02: old_val = MXLEN'(minstret[31:0]);
            12'hB82, 12'hC82: old_val = MXLEN'(minstret[63:32]);
`endif
            default: hit = 1'b0;
        endcase
    end

    assign wr_req      = csr_en && csr_op != 2'd3 && !csr_wr_suppress;
    assign csr_illegal = csr_en && (!hit || (csr_addr[11:10] == 2'b11 && wr_req));
    assign csr_rdata   = csr_illegal ? '0 : old_val;
    assign new_val     = csr_op == 2'd0 ? csr_wdata : csr_op == 2'd1 ? old_val | csr_wdata : old_val & ~csr_wdata;
    // traps and mret take priority and swallow a same-cycle CSR write
    assign wr_en       = wr_req && !csr_illegal && !trap_req && !mret_req;
    assign tvec_base   = {mtvec[MXLEN-1:2], 2'b00};
    assign trap_target = (mtvec[1:0] == 2'b01 && trap_cause[MXLEN-1]) ? tvec_base + {trap_cause[MXLEN-3:0], 2'b00} : tvec_base;

    // architectural state: trap entry, mret, then Zicsr writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= legal_tvec(RESET_MTVEC);
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
            mscratch <= '0;
        end else if (trap_req) begin
            mepc   <= trap_pc & ~MXLEN'(3);
            mcause <= trap_cause;
            mtval  <= trap_val;
            mpie   <= mie;
            mie    <= 1'b0;
        end else if (mret_req) begin
            mie  <= mpie;
            mpie <= 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                12'h300: begin
                    mie  <= new_val[3];
                    mpie <= new_val[7];
                end
                12'h305: mtvec    <= legal_tvec(new_val);
                12'h340: mscratch <= new_val;
                12'h341: mepc     <= {new_val[MXLEN-1:2], 2'b00};
                12'h342: mcause   <= new_val;
                12'h343: mtval    <= new_val;
                default: ;
            endcase
        end
    end

    // one-cycle redirect pulse; target held until the next redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= trap_req || mret_req;
            if (trap_req)
                redirect_pc <= trap_target;
            else if (mret_req)
                redirect_pc <= mepc;
        end
    end

`ifdef COTM32_CSR_COUNTERS_EN
    // free-running counters; a write to either half replaces that cycle's increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= (wr_en && csr_addr == 12'hB00) ? {mcycle[63:32], new_val[31:0]} :
                        (wr_en && csr_addr == 12'hB80) ? {new_val[31:0], mcycle[31:0]} : mcycle + 64'd1;
            minstret <= (wr_en && csr_addr == 12'hB02) ? {minstret[63:32], new_val[31:0]} :
                        (wr_en && csr_addr == 12'hB82) ? {new_val[31:0], minstret[31:0]} :
                        inst_retire ? minstret + 64'd1 : minstret;
        end
    end
`endif
endmodule

// File: tb/tb_cotm32_csr_file.sv
// tb_cotm32_csr_file: table-driven and sequenced checks of the cotm32 CSR file
module tb_cotm32_csr_file;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_en = 1'b0;
    logic [1:0]  csr_op = 2'd3;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic        csr_wr_suppress = 1'b0;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic [31:0] trap_val = '0;
    logic        mret_req = 1'b0;
    logic        inst_retire = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mstatus_mie;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic        en;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        sup;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;
    vec_t v [22];

    cotm32_csr_file #(.MXLEN(32), .HART_ID(32'd5), .RESET_MTVEC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_wr_suppress(csr_wr_suppress), .csr_rdata(csr_rdata),
        .csr_illegal(csr_illegal), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
        .trap_val(trap_val), .mret_req(mret_req), .inst_retire(inst_retire),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd, input logic sup);
        csr_en = 1'b1;
        csr_op = op;
        csr_addr = addr;
        csr_wdata = wd;
        csr_wr_suppress = sup;
    endtask

    task automatic idle;
        csr_en = 1'b0;
        csr_op = 2'd3;
        csr_wr_suppress = 1'b0;
        trap_req = 1'b0;
        mret_req = 1'b0;
        inst_retire = 1'b0;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        drive(2'd3, addr, 32'h0, 1'b0);
        #1;
        check(name, csr_rdata, exp);
        csr_en = 1'b0;
    endtask

    initial begin
        v[0]  = '{1'b1, 2'd3, 12'h305, 32'h0,    1'b0, 32'h0,    1'b0};
        v[1]  = '{1'b1, 2'd3, 12'hF14, 32'h0,    1'b0, 32'h5,    1'b0};
        v[2]  = '{1'b1, 2'd3, 12'h300, 32'h0,    1'b0, 32'h1800, 1'b0};
        v[3]  = '{1'b1, 2'd0, 12'h340, 32'h0F,   1'b0, 32'h0,    1'b0};
        v[4]  = '{1'b1, 2'd1, 12'h340, 32'hF0,   1'b0, 32'h0F,   1'b0};
        v[5]  = '{1'b1, 2'd3, 12'h340, 32'h0,    1'b0, 32'hFF,   1'b0};
        v[6]  = '{1'b1, 2'd2, 12'h340, 32'h0F,   1'b0, 32'hFF,   1'b0};
        v[7]  = '{1'b1, 2'd3, 12'h340, 32'h0,    1'b0, 32'hF0,   1'b0};
        v[8]  = '{1'b1, 2'd1, 12'h340, 32'hFF,   1'b1, 32'hF0,   1'b0};
        v[9]  = '{1'b1, 2'd3, 12'h340, 32'h0,    1'b0, 32'hF0,   1'b0};
        v[10] = '{1'b1, 2'd0, 12'hF14, 32'h1,    1'b0, 32'h0,    1'b1};
        v[11] = '{1'b1, 2'd1, 12'hF14, 32'h0,    1'b1, 32'h5,    1'b0};
        v[12] = '{1'b1, 2'd0, 12'h305, 32'h3,    1'b0, 32'h0,    1'b0};
        v[13] = '{1'b1, 2'd3, 12'h305, 32'h0,    1'b0, 32'h0,    1'b0};
        v[14] = '{1'b1, 2'd0, 12'h305, 32'h1001, 1'b0, 32'h0,    1'b0};
        v[15] = '{1'b1, 2'd3, 12'h305, 32'h0,    1'b0, 32'h1001, 1'b0};
        v[16] = '{1'b1, 2'd0, 12'h300, 32'h8,    1'b0, 32'h1800, 1'b0};
        v[17] = '{1'b1, 2'd3, 12'h300, 32'h0,    1'b0, 32'h1808, 1'b0};
        v[18] = '{1'b1, 2'd3, 12'h123, 32'h0,    1'b0, 32'h0,    1'b1};
        v[19] = '{1'b0, 2'd0, 12'h123, 32'h7,    1'b0, 32'h0,    1'b0};
        v[20] = '{1'b1, 2'd0, 12'h341, 32'h207,  1'b0, 32'h0,    1'b0};
        v[21] = '{1'b1, 2'd3, 12'h341, 32'h0,    1'b0, 32'h204,  1'b0};

        repeat (2) @(posedge clk);
        #1;
        check("reset redirect_valid", 32'(redirect_valid), 32'h0);
        check("reset redirect_pc", redirect_pc, 32'h0);
        check("reset mie", 32'(mstatus_mie), 32'h0);
        rst_n = 1'b1;
        next();

        for (int i = 0; i < 22; i++) begin
            drive(v[i].op, v[i].addr, v[i].wdata, v[i].sup);
            csr_en = v[i].en;
            #2;
            check($sformatf("vec%0d rdata", i), csr_rdata, v[i].rdata);
            check($sformatf("vec%0d illegal", i), 32'(csr_illegal), 32'(v[i].ill));
            next();
        end

        // vectored interrupt trap with a competing mscratch write
        check("mie before trap", 32'(mstatus_mie), 32'h1);
        drive(2'd0, 12'h340, 32'h5, 1'b0);
        trap_req = 1'b1;
        trap_cause = 32'h8000_0007;
        trap_pc = 32'h203;
        trap_val = 32'h55;
        next();
        check("trap redirect_valid", 32'(redirect_valid), 32'h1);
        check("trap redirect_pc", redirect_pc, 32'h101C);
        check("trap mie", 32'(mstatus_mie), 32'h0);
        rd("trap mstatus", 12'h300, 32'h1880);
        rd("trap mepc", 12'h341, 32'h200);
        rd("trap mcause", 12'h342, 32'h8000_0007);
        rd("trap mtval", 12'h343, 32'h55);
        rd("trap mscratch kept", 12'h340, 32'hF0);
        next();
        check("pulse one cycle", 32'(redirect_valid), 32'h0);
        check("redirect_pc held", redirect_pc, 32'h101C);

        // mret with a competing mscratch write
        drive(2'd0, 12'h340, 32'h77, 1'b0);
        mret_req = 1'b1;
        next();
        check("mret redirect_valid", 32'(redirect_valid), 32'h1);
        check("mret redirect_pc", redirect_pc, 32'h200);
        check("mret mie", 32'(mstatus_mie), 32'h1);
        rd("mret mstatus", 12'h300, 32'h1888);
        rd("mret mscratch kept", 12'h340, 32'hF0);

        // exception in vectored mode goes to base
        trap_req = 1'b1;
        trap_cause = 32'h2;
        trap_pc = 32'h300;
        trap_val = 32'h0;
        next();
        check("exc redirect_pc", redirect_pc, 32'h1000);

        // mepc written on N seen by mret on N+1
        drive(2'd0, 12'h341, 32'h400, 1'b0);
        next();
        mret_req = 1'b1;
        next();
        check("b2b redirect_valid", 32'(redirect_valid), 32'h1);
        check("b2b redirect_pc", redirect_pc, 32'h400);

        // reset mid-redirect clears everything at once
        trap_req = 1'b1;
        trap_cause = 32'h3;
        next();
        check("pre-reset redirect_valid", 32'(redirect_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async reset redirect_valid", 32'(redirect_valid), 32'h0);
        check("async reset redirect_pc", redirect_pc, 32'h0);
        rd("async reset mscratch", 12'h340, 32'h0);
        rd("async reset mtvec", 12'h305, 32'h0);
        rd("async reset mstatus", 12'h300, 32'h1800);
        next();
        rst_n = 1'b1;
        next();

`ifdef COTM32_CSR_COUNTERS_EN
        drive(2'd0, 12'hB00, 32'hFFFF_FFFF, 1'b0);
        next();
        drive(2'd0, 12'hB80, 32'hFFFF_FFFF, 1'b0);
        next();
        rd("mcycle all ones lo", 12'hB00, 32'hFFFF_FFFF);
        next();
        rd("mcycle wrap hi", 12'hB80, 32'h0);
        rd("mcycle wrap lo", 12'hB00, 32'h0);
        drive(2'd0, 12'hC00, 32'h1, 1'b0);
        #1;
        check("shadow write illegal", 32'(csr_illegal), 32'h1);
        idle();
        next();
        repeat (3) begin
            inst_retire = 1'b1;
            @(posedge clk);
            #1;
        end
        idle();
        rd("minstret", 12'hB02, 32'h3);
        rd("minstret shadow", 12'hC02, 32'h3);
`else
        drive(2'd3, 12'hB00, 32'h0, 1'b0);
        #1;
        check("mcycle illegal", 32'(csr_illegal), 32'h1);
        check("mcycle rdata", csr_rdata, 32'h0);
        idle();
`endif
        next();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
